// File: rtl/sram_req_bridge.sv
// Core req/gnt bus to active-low single-port SRAM strobes, with an optional post-reset
// zero sweep and an in-order rvalid/rready response FIFO.
module sram_req_bridge #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
    parameter int unsigned RESP_DEPTH     = 2,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic                  init_done_o,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [3:0]            sram_ben,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [31:0]           sram_d,
    input  logic [31:0]           sram_q
);

    localparam int unsigned PTR_W   = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(RESP_DEPTH + 1);
    localparam int unsigned TAG_LSB = ADDR_WIDTH + 2;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(RESP_DEPTH);

    typedef enum logic [0:0] {StInit, StRun} state_e;
    localparam state_e ResetState = CLEAR_ON_RESET ? StInit : StRun;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  inflight_q, inflight_d;
    logic                  infl_we_q, infl_we_d;
    logic                  infl_err_q, infl_err_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           fifo_data_q [RESP_DEPTH];
    logic [31:0]           fifo_data_d [RESP_DEPTH];
    logic                  fifo_err_q  [RESP_DEPTH];
    logic                  fifo_err_d  [RESP_DEPTH];

    logic             hit, grant, accept, push, pop;
    logic [CNT_W:0]   occ;
    logic             unused_addr;

    assign unused_addr = ^addr_i[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign hit      = addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB];
    assign rvalid_o = count_q != '0;
    assign rdata_o  = rvalid_o ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign err_o    = rvalid_o ? fifo_err_q[rd_ptr_q] : 1'b0;
    assign pop      = rvalid_o & rready_i;
    assign push     = inflight_q;
    // In-flight request already owns a FIFO slot, so it counts against the credit.
    assign occ      = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        grant       = 1'b0;
        init_done_o = 1'b0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_ben    = 4'hF;
        sram_a      = '0;
        sram_d      = 32'h0;

        case (state_q)
            StInit: begin
                if (!rst) begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_ben  = 4'h0;
                    sram_a    = clr_cnt_q;
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == '1) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (!rst) begin
                    init_done_o = 1'b1;
                    grant       = (occ - (CNT_W + 1)'(pop)) < DEPTH_L;
                    if (req_i && grant) begin
                        sram_cen  = !hit;
                        sram_gwen = !(hit & we_i);
                        sram_ben  = we_i ? ~be_i : 4'hF;
                        sram_a    = addr_i[ADDR_WIDTH+1:2];
                        sram_d    = wdata_i;
                    end
                end
            end
            default: state_d = ResetState;
        endcase
    end

    assign gnt_o  = grant;
    assign accept = req_i & grant;

    always_comb begin
        inflight_d  = accept;
        infl_we_d   = accept & we_i;
        infl_err_d  = accept & !hit;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = (!infl_we_q && !infl_err_q) ? sram_q : 32'h0;
            fifo_err_d[wr_ptr_q]  = infl_err_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ResetState;
            clr_cnt_q  <= '0;
            inflight_q <= 1'b0;
            infl_we_q  <= 1'b0;
            infl_err_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            inflight_q <= inflight_d;
            infl_we_q  <= infl_we_d;
            infl_err_q <= infl_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_err_q  <= fifo_err_d;
    end

endmodule

// File: tb/tb_sram_req_bridge.sv
// Randomised scoreboard bench for sram_req_bridge: word-array reference model, per-cycle
// strobe/credit/latency checks, and an in-order response queue popped by a monitor.
module tb_sram_req_bridge;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, gnt, we, rvalid, rready, err, init_done;
    logic [31:0]   addr, wdata, rdata, sram_d, sram_q;
    logic [3:0]    be, sram_ben;
    logic          sram_cen, sram_gwen;
    logic [AW-1:0] sram_a;

    sram_req_bridge #(
        .ADDR_WIDTH    (AW),
        .BASE_ADDR     (32'h0010_0000),
        .RESP_DEPTH    (DEPTH),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .gnt_o      (gnt),
        .addr_i     (addr),
        .we_i       (we),
        .be_i       (be),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid),
        .rready_i   (rready),
        .rdata_o    (rdata),
        .err_o      (err),
        .init_done_o(init_done),
        .sram_cen   (sram_cen),
        .sram_gwen  (sram_gwen),
        .sram_ben   (sram_ben),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model, preloaded with garbage so the clear sweep is observable.
    logic [31:0] mem [WORDS];
    initial begin
        sram_q = 32'h0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom | 32'h1;
    end
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_ben[b]) mem[sram_a][8*b +: 8] <= sram_d[8*b +: 8];
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [WORDS];
    int          sweep_idx = 0;
    bit          prev_rst  = 1'b0;
    int unsigned cyc       = 0;

    // Monitor / reference model: everything sampled on the falling edge.
    always @(negedge clk) begin
        logic        pop, acc, hit, exp_gnt;
        logic [41:0] exp_strb;
        int          idx;
        exp_t        e;
        cyc++;
        if (rst) begin
            q.delete();
            sweep_idx = 0;
            prev_rst  = 1'b1;
            chk("rst_gnt", gnt, 0);
            chk("rst_cen", sram_cen, 1);
        end else begin
            if (prev_rst) begin
                chk("post_rst_rvalid", rvalid, 0);
                chk("post_rst_init_done", init_done, 0);
            end
            prev_rst = 1'b0;
            chk("gwen_without_cen", !sram_gwen & sram_cen, 0);
            if (sweep_idx < WORDS) begin
                chk("sweep_strobes", {sram_cen, sram_gwen, sram_ben, sram_d}, 0);
                chk("sweep_addr", sram_a, sweep_idx);
                chk("sweep_gnt", gnt, 0);
                chk("sweep_init_done", init_done, 0);
                sweep_idx++;
                if (sweep_idx == WORDS)
                    for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
            end else begin
                chk("init_done", init_done, 1);
                pop     = rvalid & rready;
                exp_gnt = (q.size() - int'(pop)) < DEPTH;
                chk("gnt_credit", gnt, exp_gnt);
                acc = req & gnt;
                hit = addr[31:AW+2] == 32'h0010_0000 >> (AW + 2);
                idx = int'(addr[AW+1:2]);
                if (acc)
                    exp_strb = {!hit, !(hit & we), we ? ~be : 4'hF, addr[AW+1:2], wdata};
                else
                    exp_strb = {1'b1, 1'b1, 4'hF, {AW{1'b0}}, 32'h0};
                chk("sram_strobes", {sram_cen, sram_gwen, sram_ben, sram_a, sram_d}, exp_strb);
                if (q.size() == 0) begin
                    chk("empty_outputs", {rvalid, err, rdata}, 0);
                end else begin
                    chk("rvalid_timing", rvalid, cyc >= q[0].cyc + 2);
                    if (pop) begin
                        e = q.pop_front();
                        chk("resp_rdata", rdata, e.rdata);
                        chk("resp_err", err, e.err);
                    end
                end
                if (acc) begin
                    e.cyc = cyc;
                    e.err = !hit;
                    e.rdata = 32'h0;
                    if (hit && we) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                    end else if (hit) begin
                        e.rdata = ref_mem[idx];
                    end
                    q.push_back(e);
                end
            end
        end
    end

    // rready driver: 0 = always ready, 1 = random, 2 = stalled.
    int rr_mode = 0;
    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       rready = 1'b1;
                1:       rready = 1'($urandom_range(0, 1));
                default: rready = 1'b0;
            endcase
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0;
        cycle();
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        int n = 0;
        req = 1'b1; we = w; addr = a; be = b; wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt && n < 20);
        if (!gnt) chk("gnt_timeout", gnt, 1);
        cycle();
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("init_timeout", init_done, 1);
        cycle();
    endtask

    initial begin
        int n_gnt;
        int n;
        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        repeat (5) cycle();
        rst = 1'b1;                      // restart the sweep part-way through
        cycle();
        rst = 1'b0;
        wait_init();

        issue(1'b0, 32'h0010_0020, 4'hF, 32'h0);
        issue(1'b1, 32'h0010_0008, 4'hF, 32'hDEAD_BEEF);
        issue(1'b0, 32'h0010_0008, 4'hF, 32'h0);
        issue(1'b1, 32'h0010_000C, 4'hF, 32'h1122_3344);
        issue(1'b1, 32'h0010_000C, 4'b0010, 32'h0000_AB00);
        issue(1'b0, 32'h0010_000C, 4'hF, 32'h0);
        issue(1'b1, 32'h0010_0004, 4'h0, 32'hFFFF_FFFF);
        issue(1'b0, 32'h0020_0000, 4'hF, 32'h0);
        issue(1'b1, 32'h0020_0004, 4'hF, 32'h5555_AAAA);
        idle();
        repeat (4) cycle();

        // Back-pressure: stall rready with req held high.
        rr_mode = 2;
        cycle();
        req = 1'b1; we = 1'b0; addr = 32'h0010_0008; be = 4'hF;
        n_gnt = 0;
        repeat (8) begin
            @(negedge clk);
            n_gnt += int'(gnt);
        end
        chk("bp_grants", n_gnt, DEPTH);
        cycle();
        rr_mode = 0;
        @(negedge clk);
        chk("bp_gnt_return", gnt, 1);
        cycle();
        repeat (3) cycle();
        idle();
        repeat (4) cycle();

        rr_mode = 1;
        repeat (400) begin
            req   = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            be    = 4'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 7) == 0) addr = $urandom;
            else addr = 32'h0010_0000 | ($urandom & 32'h3F);
            cycle();
        end
        idle();
        rr_mode = 0;
        repeat (6) cycle();

        // Reset with two responses buffered: both must be dropped.
        rr_mode = 2;
        cycle();
        issue(1'b0, 32'h0010_0008, 4'hF, 32'h0);
        issue(1'b0, 32'h0010_000C, 4'hF, 32'h0);
        idle();
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        rr_mode = 0;
        wait_init();
        issue(1'b1, 32'h0010_0010, 4'hF, 32'hCAFE_F00D);
        issue(1'b0, 32'h0010_0010, 4'hF, 32'h0);
        issue(1'b0, 32'h0010_0008, 4'hF, 32'h0);
        idle();

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        repeat (5) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_bridge.md
Name: sram_req_bridge

Overview:
- Upstream stage of the 16384x32 byte-enable single-port SRAM wrapper.
- Converts the core-side req/gnt memory bus (addr, we, be, wdata) into the SRAM's active-low CEN/GWEN/BEN strobes.
- Returns every access (read or write) as an in-order response through a small rvalid/rready response FIFO.
- Optionally zero-fills the whole array after reset before accepting traffic.

Parameters:
- ADDR_WIDTH, 14, SRAM word-address width (array holds 2**ADDR_WIDTH 32-bit words).
- BASE_ADDR, 32'h0010_0000, byte base address. Only bits [31:ADDR_WIDTH+2] are compared.
- RESP_DEPTH, 2, response FIFO depth (>=2). Includes the in-flight slot in the credit count.
- CLEAR_ON_RESET, 1, when 1, sweep-write zero to all words after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle (handshake = req_i & gnt_o)
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1=write, 0=read
- be_i  in  4  byte enables, active-high
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rready_i  in  1  response consumed
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  address out of range
- init_done_o  out  1  clear sweep finished, bus open
- sram_cen  out  1  SRAM chip enable, active-low
- sram_gwen  out  1  SRAM global write enable, active-low
- sram_ben  out  4  SRAM byte enables, active-low
- sram_a  out  ADDR_WIDTH  SRAM word address
- sram_d  out  32  SRAM write data
- sram_q  in  32  SRAM read data, valid 1 cycle after an enabled read

Behaviour:

Reset (rst=1 at a clock edge):
- FSM goes to INIT (CLEAR_ON_RESET=1) or RUN (=0).
- Clear counter, FIFO and in-flight flag are cleared.
- Outputs: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, init_done_o=0.
- SRAM idle encoding: cen=1, gwen=1, ben=4'hF, a=0, d=0.
- Reset mid-sweep restarts the sweep at word 0.
- Reset mid-traffic drops the in-flight and buffered responses; they are never delivered.

INIT state:
- Each cycle drives cen=0, gwen=0, ben=4'h0, d=0, a=counter, then increments the counter.
- After word 2**ADDR_WIDTH-1 is written, go to RUN.
- Sweep takes exactly 2**ADDR_WIDTH cycles; gnt_o=0 throughout.
- GWEN is never low while CEN is high: the SRAM enables on either strobe.

RUN state:
- init_done_o=1.
- Credit rule: occ = fifo_count + inflight; pop = rvalid_o & rready_i; gnt_o = (occ - pop) < RESP_DEPTH.
- gnt_o is combinational on rready_i and independent of req_i.

Accepted request in cycle N:
- hit = addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2].
- SRAM strobes are driven combinationally in cycle N: cen = !hit, gwen = !(hit & we_i), ben = we_i ? ~be_i : 4'hF, a = addr_i[ADDR_WIDTH+1:2], d = wdata_i.
- Write with be_i=0: SRAM enabled, no bytes change, response OK.
- Miss: no SRAM strobe, err=1, rdata=0.
- No accepted request in a cycle: idle encoding.

In-flight stage:
- inflight, tag {we, err} registered at the end of N.
- Response pushed to the FIFO at the end of N+1, rdata = (!we & !err) ? sram_q : 0.

Response FIFO:
- rvalid_o first asserted in cycle N+2.
- Unstalled, the bridge sustains 1 request/cycle.
- Responses are in order. The head holds stable until rready_i.
- Push and pop in the same cycle are both allowed.
- Overflow is impossible by the credit rule; no assertion-free overflow path exists.
- Empty FIFO: rvalid_o=0, rdata_o=0, err_o=0.

Read-after-write to the same address in consecutive cycles returns the new data: the SRAM is single-port and the write completes at edge N.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_WIDTH=4 → exactly 16 cycles of cen=0/gwen=0/ben=0 with a=0..15, then init_done_o=1. A subsequent read of 0x0010_0020 returns 0.
- Write 0xDEADBEEF be=F to 0x0010_0008, then read the same address in the next cycle, rready_i=1 → responses in cycles N+2 and N+3, the second with rdata=0xDEADBEEF, err=0.
- Partial write be=4'b0010 data 0x0000AB00 over 0x11223344 → read returns 0x1122AB44. sram_ben=4'b1101 during the write.
- Read of 0x0020_0000 (miss) → no SRAM strobe that cycle, response err_o=1, rdata_o=0.
- rready_i=0 with req_i held high → gnt_o for exactly RESP_DEPTH requests, then 0. Raising rready_i drains in order and gnt_o returns in the same cycle.
- rst asserted mid-sweep and with 2 responses buffered → rvalid_o=0 next cycle, sweep restarts at a=0, and no stale response appears afterwards.
